// File: rtl/axi4l_gpio_irq_slave_if.sv
// AXI4-Lite bus bundle for axi4l_gpio_irq_slave: master drives requests, slave drives responses.
interface axi4l_gpio_irq_slave_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_gpio_irq_slave.sv
// AXI4-Lite LED / interrupt aggregation register block.
// Define AXIL_SLVERR_EN to answer unmapped register indices with SLVERR instead of OKAY.
module axi4l_gpio_irq_slave #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [31:0] ID_VALUE   = 32'hA11E_0002
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axi4l_gpio_irq_slave_if.slave        s_axi,
  input  logic [NUM_IRQ-1:0]           EXT_IRQ_IN,
  output logic [NUM_LEDS-1:0]          LED,
  output logic                         IRQ_OUT
);

  localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;

  localparam logic [IDX_W-1:0] IDX_LED     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_IRQ_EN  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_IRQ_ST  = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_IRQ_RAW = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(5);

`ifdef AXIL_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [NUM_LEDS-1:0]   led_q;
  logic [NUM_IRQ-1:0]    irq_en_q, irq_status_q;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic [NUM_IRQ-1:0]    sync1, sync2, sync3;
  logic                  irq_out_q;

  logic                  aw_hs, w_hs, ar_hs, wr_commit, wr_mapped;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;
  logic [NUM_IRQ-1:0]    irq_rise, status_clr;
  logic                  unused_bits;

  assign s_axi.awready = !aw_held && !bvalid_q && !ARESET;
  assign s_axi.wready  = !w_held && !bvalid_q && !ARESET;
  assign s_axi.arready = !rvalid_q && !ARESET;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign LED           = led_q;
  assign IRQ_OUT       = irq_out_q;

  assign aw_hs     = s_axi.awvalid && s_axi.awready;
  assign w_hs      = s_axi.wvalid && s_axi.wready;
  assign ar_hs     = s_axi.arvalid && s_axi.arready;
  assign wr_commit = aw_held && w_held;
  assign wr_mapped = (wr_idx <= IDX_ID);
  assign rd_idx    = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign irq_rise  = sync2 & ~sync3;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  always_comb begin
    wr_mask = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      wr_mask[i*8 +: 8] = {8{w_strb_q[i]}};
    end
  end

  always_comb begin
    status_clr = '0;
    if (wr_commit && wr_idx == IDX_IRQ_ST) begin
      status_clr = NUM_IRQ'(w_data_q & wr_mask);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      IDX_LED:     rd_data = DATA_WIDTH'(led_q);
      IDX_IRQ_EN:  rd_data = DATA_WIDTH'(irq_en_q);
      IDX_IRQ_ST:  rd_data = DATA_WIDTH'(irq_status_q);
      IDX_IRQ_RAW: rd_data = DATA_WIDTH'(sync2);
      IDX_SCRATCH: rd_data = scratch_q;
      IDX_ID:      rd_data = DATA_WIDTH'(ID_VALUE);
      default:     rd_err  = 1'b1;
    endcase
  end

  // AW and W park independently; the commit happens on the edge after both are parked.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      wr_idx   <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        wr_idx  <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi.wdata;
        w_strb_q <= s_axi.wstrb;
      end
      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (SLVERR_EN && !wr_mapped) ? 2'b10 : 2'b00;
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= (SLVERR_EN && rd_err) ? 2'b10 : 2'b00;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      led_q     <= '0;
      irq_en_q  <= '0;
      scratch_q <= '0;
    end else if (wr_commit) begin
      case (wr_idx)
        IDX_LED:     led_q     <= NUM_LEDS'((DATA_WIDTH'(led_q) & ~wr_mask) | (w_data_q & wr_mask));
        IDX_IRQ_EN:  irq_en_q  <= NUM_IRQ'((DATA_WIDTH'(irq_en_q) & ~wr_mask) | (w_data_q & wr_mask));
        IDX_SCRATCH: scratch_q <= (scratch_q & ~wr_mask) | (w_data_q & wr_mask);
        default:     ;
      endcase
    end
  end

  // Rising edge is ORed in after the W1C clear so a coincident new edge survives.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync1        <= '0;
      sync2        <= '0;
      sync3        <= '0;
      irq_status_q <= '0;
      irq_out_q    <= 1'b0;
    end else begin
      sync1        <= EXT_IRQ_IN;
      sync2        <= sync1;
      sync3        <= sync2;
      irq_status_q <= (irq_status_q & ~status_clr) | irq_rise;
      irq_out_q    <= |(irq_status_q & irq_en_q);
    end
  end

endmodule

// File: tb/tb_axi4l_gpio_irq_slave.sv
// Scoreboard bench for axi4l_gpio_irq_slave: driver queues expected B/R responses, monitor checks them.
module tb_axi4l_gpio_irq_slave;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 8;
  localparam int unsigned NI = 4;
  localparam logic [31:0] ID = 32'hA11E_0002;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [NI-1:0] ext = '0;
  logic [NL-1:0] led;
  logic          irq_out;

  int checks = 0;
  int failures = 0;

  string       bname_q[$];
  logic [1:0]  bexp_q[$];
  string       rname_q[$];
  logic [33:0] rexp_q[$];

  axi4l_gpio_irq_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

  axi4l_gpio_irq_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LEDS(NL), .NUM_IRQ(NI), .ID_VALUE(ID)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_axi(s_axi),
    .EXT_IRQ_IN(ext), .LED(led), .IRQ_OUT(irq_out)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completed B / R handshake with the oldest queued expectation.
  initial begin
    string nm;
    logic [1:0] be;
    logic [33:0] re;
    forever begin
      @(negedge ACLK);
      if (!ARESET && s_axi.bvalid && s_axi.bready) begin
        if (bexp_q.size() == 0) begin
          check("b_unexpected", 1, 0);
        end else begin
          nm = bname_q.pop_front();
          be = bexp_q.pop_front();
          check(nm, s_axi.bresp, be);
        end
      end
      if (!ARESET && s_axi.rvalid && s_axi.rready) begin
        if (rexp_q.size() == 0) begin
          check("r_unexpected", 1, 0);
        end else begin
          nm = rname_q.pop_front();
          re = rexp_q.pop_front();
          check(nm, {s_axi.rresp, s_axi.rdata}, re);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_aw(input logic [7:0] a);
    int n;
    n = 0;
    s_axi.awaddr = a;
    s_axi.awvalid = 1'b1;
    @(negedge ACLK);
    while (!s_axi.awready && n < 50) begin @(negedge ACLK); n++; end
    check("aw_handshake", s_axi.awready, 1);
    @(posedge ACLK); #1;
    s_axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    s_axi.wdata = d;
    s_axi.wstrb = s;
    s_axi.wvalid = 1'b1;
    @(negedge ACLK);
    while (!s_axi.wready && n < 50) begin @(negedge ACLK); n++; end
    check("w_handshake", s_axi.wready, 1);
    @(posedge ACLK); #1;
    s_axi.wvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    @(negedge ACLK);
    while (!s_axi.bvalid && n < 50) begin @(negedge ACLK); n++; end
    check("b_arrive", s_axi.bvalid, 1);
    @(posedge ACLK); #1;
  endtask

  task automatic do_write(input string name, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    bname_q.push_back(name);
    bexp_q.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b();
  endtask

  task automatic do_read(input string name, input logic [7:0] a, input logic [31:0] d,
                         input logic [1:0] resp);
    int n;
    n = 0;
    rname_q.push_back(name);
    rexp_q.push_back({resp, d});
    s_axi.araddr = a;
    s_axi.arvalid = 1'b1;
    @(negedge ACLK);
    while (!s_axi.arready && n < 50) begin @(negedge ACLK); n++; end
    check("ar_handshake", s_axi.arready, 1);
    @(posedge ACLK); #1;
    s_axi.arvalid = 1'b0;
    @(negedge ACLK);
    @(posedge ACLK); #1;
  endtask

  initial begin
    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0;  s_axi.wstrb = '0;  s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b1;
    s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", s_axi.awready, 0);
    check("rst_wready", s_axi.wready, 0);
    check("rst_arready", s_axi.arready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_rdata", s_axi.rdata, 0);
    check("rst_led", led, 0);
    check("rst_irq_out", irq_out, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("idle_awready", s_axi.awready, 1);
    @(posedge ACLK); #1;

    // AW+W together at LED, BVALID one edge after the handshake
    bname_q.push_back("b_led");
    bexp_q.push_back(2'b00);
    fork
      send_aw(8'h00);
      send_w(32'h0000_00A5, 4'hF);
    join
    @(negedge ACLK);
    check("led_bvalid_early", s_axi.bvalid, 0);
    @(negedge ACLK);
    check("led_bvalid", s_axi.bvalid, 1);
    check("led_out", led, 8'hA5);
    @(posedge ACLK); #1;
    do_read("r_led", 8'h00, 32'h0000_00A5, 2'b00);
    do_read("r_led_lowbits", 8'h03, 32'h0000_00A5, 2'b00);

    // W leads AW by 3 cycles, partial strobes, B stalled 5 cycles
    s_axi.bready = 1'b0;
    bname_q.push_back("b_scratch");
    bexp_q.push_back(2'b00);
    send_w(32'hDEAD_BEEF, 4'b0101);
    repeat (2) @(posedge ACLK);
    #1;
    send_aw(8'h10);
    @(posedge ACLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("stall_bvalid", s_axi.bvalid, 1);
      check("stall_bresp", s_axi.bresp, 2'b00);
      check("stall_awready", s_axi.awready, 0);
    end
    @(posedge ACLK); #1;
    s_axi.bready = 1'b1;
    wait_b();
    do_read("r_scratch", 8'h10, 32'h00AD_00EF, 2'b00);

    // IRQ path: enable bit 2, one-cycle pulse, IRQ_OUT on the 4th edge
    do_write("b_irq_en", 8'h04, 32'h4, 4'hF, 2'b00);
    do_read("r_irq_en", 8'h04, 32'h4, 2'b00);
    @(posedge ACLK); #1;
    ext = 4'b0100;
    @(posedge ACLK); #1;
    ext = 4'b0000;
    @(posedge ACLK);
    @(posedge ACLK);
    @(negedge ACLK);
    check("irq_out_edge3", irq_out, 0);
    @(posedge ACLK);
    @(negedge ACLK);
    check("irq_out_edge4", irq_out, 1);
    @(posedge ACLK); #1;
    do_read("r_irq_status", 8'h08, 32'h4, 2'b00);
    do_read("r_irq_raw", 8'h0C, 32'h0, 2'b00);

    // W1C drops IRQ_OUT two edges after the handshake
    bname_q.push_back("b_w1c");
    bexp_q.push_back(2'b00);
    fork
      send_aw(8'h08);
      send_w(32'h4, 4'hF);
    join
    @(negedge ACLK);
    check("w1c_irq_k", irq_out, 1);
    @(negedge ACLK);
    check("w1c_irq_k1", irq_out, 1);
    @(negedge ACLK);
    check("w1c_irq_k2", irq_out, 0);
    @(posedge ACLK); #1;
    do_read("r_status_cleared", 8'h08, 32'h0, 2'b00);

    // W1C commit coincides with a fresh rising edge: set wins
    bname_q.push_back("b_w1c_collide");
    bexp_q.push_back(2'b00);
    @(posedge ACLK); #1;
    ext = 4'b0100;
    @(posedge ACLK); #1;
    ext = 4'b0000;
    s_axi.awaddr = 8'h08; s_axi.awvalid = 1'b1;
    s_axi.wdata = 32'h4;  s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    @(negedge ACLK);
    check("collide_awready", s_axi.awready, 1);
    check("collide_wready", s_axi.wready, 1);
    @(posedge ACLK); #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    wait_b();
    check("collide_irq_out", irq_out, 1);
    do_read("r_status_collide", 8'h08, 32'h4, 2'b00);
    do_write("b_w1c_final", 8'h08, 32'hF, 4'hF, 2'b00);
    do_read("r_status_final", 8'h08, 32'h0, 2'b00);

    // Unmapped and read-only accesses
    do_read("r_unmapped", 8'h1C, 32'h0, UNMAP_RESP);
    do_read("r_id", 8'h14, ID, 2'b00);
    do_write("b_unmapped", 8'h18, 32'hFFFF_FFFF, 4'hF, UNMAP_RESP);
    do_write("b_id_ro", 8'h14, 32'h1234_5678, 4'hF, 2'b00);
    do_read("r_id_after_write", 8'h14, ID, 2'b00);
    do_read("r_led_unchanged", 8'h00, 32'h0000_00A5, 2'b00);

    // Reset while BVALID pending and the master presents another AW/W
    s_axi.bready = 1'b0;
    fork
      send_aw(8'h00);
      send_w(32'h3C, 4'hF);
    join
    @(posedge ACLK);
    @(negedge ACLK);
    check("pre_rst_bvalid", s_axi.bvalid, 1);
    check("pre_rst_led", led, 8'h3C);
    @(posedge ACLK); #1;
    s_axi.awaddr = 8'h00; s_axi.awvalid = 1'b1;
    s_axi.wdata = 32'hFF; s_axi.wvalid = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b0;
    @(negedge ACLK);
    check("post_rst_bvalid", s_axi.bvalid, 0);
    check("post_rst_led", led, 0);
    @(posedge ACLK); #1;
    s_axi.bready = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      check("post_rst_no_b", s_axi.bvalid, 0);
      check("post_rst_led_hold", led, 0);
    end
    @(posedge ACLK); #1;

    // Held AW discarded by reset; a later lone W must not commit to it
    send_aw(8'h00);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    send_w(32'h77, 4'hF);
    repeat (3) begin
      @(negedge ACLK);
      check("stale_no_b", s_axi.bvalid, 0);
      check("stale_led", led, 0);
    end
    @(posedge ACLK); #1;
    bname_q.push_back("b_scratch_pair");
    bexp_q.push_back(2'b00);
    send_aw(8'h10);
    wait_b();
    do_read("r_scratch_pair", 8'h10, 32'h0000_0077, 2'b00);
    do_read("r_led_after_rst", 8'h00, 32'h0, 2'b00);

    repeat (5) @(posedge ACLK);
    check("sb_b_empty", bexp_q.size(), 0);
    check("sb_r_empty", rexp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4l_gpio_irq_slave.md
Name: axi4l_gpio_irq_slave

Overview:
- Parametrised AXI4-Lite slave register block: the successor of the fixed single-IRQ LED peripheral on the S_AXI bus.
- Drives NUM_LEDS LED outputs and aggregates NUM_IRQ external interrupt lines into one masked IRQ_OUT.
- Accepts AW and W independently, in either order; exactly one write and one read outstanding.
- Sits directly behind the interconnect and is driven by the existing AXI4-Lite agent through its interface.

Parameters:
ADDR_WIDTH, 8, byte address width; at least 5.
DATA_WIDTH, 32, data width; 32 or 64. Register stride is DATA_WIDTH/8 bytes.
NUM_LEDS, 8, LED output count; 1..DATA_WIDTH.
NUM_IRQ, 4, external interrupt input count; 1..DATA_WIDTH.
ID_VALUE, 32'hA11E_0002, constant returned by ID register, zero-extended to DATA_WIDTH.

Ports:
ACLK  in  1  clock, all logic on posedge
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
EXT_IRQ_IN  in  NUM_IRQ  asynchronous interrupt sources
LED  out  NUM_LEDS  LED drive
IRQ_OUT  out  1  registered interrupt request

Behaviour:
- Single clock ACLK; reset ARESET is synchronous and active-high. While ARESET=1 at a posedge, all state clears.
- Reset values: AWREADY, WREADY, ARREADY, BVALID, RVALID, IRQ_OUT = 0; BRESP, RRESP, RDATA, LED = 0. All registers = 0 and both synchronisers = 0.
- Register index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. Low address bits are ignored.
  - 0 LED (RW): bits [NUM_LEDS-1:0].
  - 1 IRQ_EN (RW): bits [NUM_IRQ-1:0].
  - 2 IRQ_STATUS (R/W1C).
  - 3 IRQ_RAW (RO): synchronised inputs.
  - 4 SCRATCH (RW): full width.
  - 5 ID (RO).
  - Other indices are unmapped.
- Unimplemented bits read 0. Writes honour WSTRB per byte. Writes to RO registers are ignored with OKAY.
- Write path:
  - AWREADY = !aw_held && !BVALID && !ARESET. WREADY = !w_held && !BVALID && !ARESET.
  - AW and W are captured independently; either order and same-cycle arrival are all legal.
  - On the edge after both are held: the register updates, BVALID=1, BRESP is set, and both held flags clear.
  - BVALID holds, with BRESP stable, until BREADY is sampled high. No new AW/W is accepted while BVALID=1.
  - Minimum write latency: AW+W handshake at edge k, BVALID at edge k+1.
- Read path:
  - ARREADY = !RVALID && !ARESET.
  - AR handshake at edge k: RDATA/RRESP are registered and RVALID=1 at edge k.
  - RVALID, RDATA and RRESP hold until RREADY is sampled high.
  - Reads do not clear any state.
  - Read and write in the same cycle to the same register: the read returns the pre-write value.
- IRQ:
  - Each EXT_IRQ_IN bit goes through a 2-flop synchroniser (the IRQ_RAW value), then a 3rd flop for edge detection.
  - A rising edge sets the corresponding IRQ_STATUS bit.
  - A W1C write clears status bits that are written 1 within strobed bytes.
  - Set and clear on the same edge for the same bit: set wins.
  - IRQ_OUT <= |(IRQ_STATUS & IRQ_EN), registered, one cycle after status/enable change.
  - Input rise to IRQ_OUT = 4 edges when enabled.
- Reset mid-transaction: held AW/W and pending B/R are discarded; no response is issued after reset.

Optional Feature:
Macro AXIL_SLVERR_EN.
- Defined: access to an unmapped index returns BRESP/RRESP = 2'b10 (SLVERR); read data = 0; write has no effect.
- Undefined: unmapped access returns OKAY (2'b00), read data 0, write ignored.
- Mapped accesses are always OKAY.

Test Plan:
- Reset, then AW and W together at 0x00 with data 0xA5 and WSTRB 0xF -> BVALID one cycle later, BRESP=00, LED=8'hA5; read 0x00 -> RDATA=0x000000A5.
- W precedes AW by 3 cycles, SCRATCH write 0xDEADBEEF with WSTRB 4'b0101 after prior 0 -> SCRATCH reads 0x00AD00EF. With BREADY low 5 cycles: BVALID and BRESP stay stable, AWREADY=0 throughout.
- IRQ_EN=0x4; pulse EXT_IRQ_IN[2] for 1 cycle -> IRQ_STATUS=0x4, IRQ_OUT=1 four edges after the rise. Write 0x4 to IRQ_STATUS -> IRQ_OUT=0 two edges later.
- W1C of bit 2 on the same edge a new rising edge of EXT_IRQ_IN[2] is detected -> IRQ_STATUS bit 2 stays 1.
- Read index 7 (0x1C): with AXIL_SLVERR_EN -> RRESP=10, RDATA=0; without it -> RRESP=00. Read 0x14 -> ID_VALUE.
- ARESET asserted while BVALID=1 and AW is held -> next cycle BVALID=0, LED=0, and no stale write is committed after release.
